// File: rtl/soc_addr_router_if.sv
// Request, forwarded-request, target-response and decode-error channels of soc_addr_router.
// The slave modport is the router's view; master is the core/target-side view.
interface soc_addr_router_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int ID_WIDTH   = 4,
   parameter int NUM_SLAVES = 10
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [ID_WIDTH-1:0]   req_id_i;
   logic                  req_we_i;
   logic [NUM_SLAVES-1:0] slv_valid_o;
   logic [NUM_SLAVES-1:0] slv_ready_i;
   logic [ADDR_WIDTH-1:0] slv_addr_o;
   logic [ID_WIDTH-1:0]   slv_id_o;
   logic                  slv_we_o;
   logic [NUM_SLAVES-1:0] rsp_valid_i;
   logic [NUM_SLAVES-1:0] rsp_ready_o;
   logic                  err_rsp_valid_o;
   logic [ID_WIDTH-1:0]   err_rsp_id_o;
   logic                  err_rsp_ready_i;

   modport slave (
      input  req_valid_i, req_addr_i, req_id_i, req_we_i,
      input  slv_ready_i, rsp_valid_i, err_rsp_ready_i,
      output req_ready_o, slv_valid_o, slv_addr_o, slv_id_o, slv_we_o,
      output rsp_ready_o, err_rsp_valid_o, err_rsp_id_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_id_i, req_we_i,
      output slv_ready_i, rsp_valid_i, err_rsp_ready_i,
      input  req_ready_o, slv_valid_o, slv_addr_o, slv_id_o, slv_we_o,
      input  rsp_ready_o, err_rsp_valid_o, err_rsp_id_o
   );
endinterface

// File: rtl/soc_addr_router.sv
// Address-decoding request router: one registered forward stage (1 cycle min), in-order per target, stalls on target switch or full count.
// Optional saturating decode-error counter enabled by SOC_ROUTER_ERR_COUNT_EN.
module soc_addr_router #(
   parameter int ADDR_WIDTH      = 64,
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 8,
   parameter int NUM_SLAVES      = 10
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   soc_addr_router_if.slave                     bus,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   output logic [15:0]                          err_count_o
);
   localparam int CNT_W       = $clog2(MAX_OUTSTANDING + 1);
   localparam int TGT_W       = $clog2(NUM_SLAVES);
   localparam int AX_W        = ADDR_WIDTH + 1;
   localparam int NUM_REGIONS = 10;

   localparam logic [63:0] REGION_BASE [NUM_REGIONS] = '{
      64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000, 64'h1800_0000,
      64'h1000_0000, 64'h0C00_0000, 64'h0200_0000, 64'h0001_0000, 64'h0000_0000
   };
   localparam logic [63:0] REGION_LEN [NUM_REGIONS] = '{
      64'h4000_0000, 64'h0000_1000, 64'h0001_0000, 64'h0080_0000, 64'h0000_1000,
      64'h0000_1000, 64'h03FF_FFFF, 64'h000C_0000, 64'h0001_0000, 64'h0000_1000
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      ERR  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic                  we_q, we_d;
   logic [TGT_W-1:0]      tgt_q, tgt_d;
   logic [CNT_W-1:0]      out_q, out_d;

   logic                  dec_hit;
   logic [TGT_W-1:0]      dec_idx;
   logic                  stall;
   logic                  req_ready;
   logic                  fwd_hs;
   logic                  rsp_hs;
   logic [NUM_SLAVES-1:0] tgt_oh;

   // Upper bound computed one bit wider so base+length never wraps.
   always_comb begin
      logic [AX_W-1:0] addr_x;
      logic [AX_W-1:0] lo;
      logic [AX_W-1:0] hi;
      addr_x  = {1'b0, bus.req_addr_i};
      lo      = '0;
      hi      = '0;
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         lo = AX_W'(REGION_BASE[i]);
         hi = lo + AX_W'(REGION_LEN[i]);
         if ((addr_x >= lo) && (addr_x < hi)) begin
            dec_hit = 1'b1;
            dec_idx = TGT_W'(i);
         end
      end
   end

   assign tgt_oh = NUM_SLAVES'(1) << tgt_q;
   assign stall  = (out_q == CNT_W'(MAX_OUTSTANDING)) ||
                   ((out_q != '0) && (!dec_hit || (dec_idx != tgt_q)));
   assign fwd_hs = (state_q == FWD) && bus.slv_ready_i[tgt_q];
   assign rsp_hs = |(bus.rsp_valid_i & bus.rsp_ready_o);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      id_d      = id_q;
      we_d      = we_q;
      tgt_d     = tgt_q;
      req_ready = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = !stall;
            if (bus.req_valid_i && !stall) begin
               id_d = bus.req_id_i;
               if (dec_hit) begin
                  addr_d  = bus.req_addr_i;
                  we_d    = bus.req_we_i;
                  tgt_d   = dec_idx;
                  state_d = FWD;
               end else begin
                  state_d = ERR;
               end
            end
         end
         FWD: begin
            if (bus.slv_ready_i[tgt_q]) begin
               state_d = IDLE;
            end
         end
         ERR: begin
            if (bus.err_rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_d = out_q;
      if (fwd_hs && !rsp_hs) begin
         out_d = out_q + CNT_W'(1);
      end else if (!fwd_hs && rsp_hs) begin
         out_d = out_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         id_q    <= '0;
         we_q    <= 1'b0;
         tgt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         we_q    <= we_d;
         tgt_q   <= tgt_d;
         out_q   <= out_d;
      end
   end

   assign bus.req_ready_o     = req_ready;
   assign bus.slv_valid_o     = (state_q == FWD) ? tgt_oh : '0;
   assign bus.slv_addr_o      = addr_q;
   assign bus.slv_id_o        = id_q;
   assign bus.slv_we_o        = we_q;
   // Only the current target may answer; it is the only one with anything in flight.
   assign bus.rsp_ready_o     = (out_q != '0) ? tgt_oh : '0;
   assign bus.err_rsp_valid_o = (state_q == ERR);
   assign bus.err_rsp_id_o    = id_q;
   assign outstanding_o       = out_q;

`ifdef SOC_ROUTER_ERR_COUNT_EN
   logic        err_hs;
   logic [15:0] err_cnt_q, err_cnt_d;

   assign err_hs = (state_q == ERR) && bus.err_rsp_ready_i;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_hs && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count_o = err_cnt_q;
`else
   assign err_count_o = 16'h0000;
`endif
endmodule

// File: tb/tb_soc_addr_router.sv
// Bench for soc_addr_router: decode vector table, hand-written ordering/fill/reset sequences,
// then random traffic compared against a transaction-level model of the router.
`timescale 1ns/1ps
module tb_soc_addr_router;
   localparam int AW   = 64;
   localparam int IW   = 4;
   localparam int MAXO = 8;
   localparam int NS   = 10;
   localparam int CW   = $clog2(MAXO + 1);

   localparam logic [63:0] M_BASE [NS] = '{
      64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000, 64'h1800_0000,
      64'h1000_0000, 64'h0C00_0000, 64'h0200_0000, 64'h0001_0000, 64'h0000_0000
   };
   localparam logic [63:0] M_LEN [NS] = '{
      64'h4000_0000, 64'h0000_1000, 64'h0001_0000, 64'h0080_0000, 64'h0000_1000,
      64'h0000_1000, 64'h03FF_FFFF, 64'h000C_0000, 64'h0001_0000, 64'h0000_1000
   };

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic [CW-1:0] outstanding_o;
   logic [15:0]   err_count_o;

   soc_addr_router_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .NUM_SLAVES(NS)) bus ();

   soc_addr_router #(
      .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO), .NUM_SLAVES(NS)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bus          (bus.slave),
      .outstanding_o(outstanding_o),
      .err_count_o  (err_count_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;
   int exp_errs = 0;

   typedef struct packed {
      logic [63:0] addr;
      logic [3:0]  id;
      logic [9:0]  exp_vld;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [63:0] a;
      logic [3:0]  id;
      logic        we;
      int          tgt;
   } txn_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_i);
   endtask

   function automatic logic [15:0] exp_ec();
`ifdef SOC_ROUTER_ERR_COUNT_EN
      return (exp_errs > 65535) ? 16'hFFFF : 16'(exp_errs);
`else
      return 16'h0000;
`endif
   endfunction

   // Region index that owns the address, or -1 when nothing claims it.
   function automatic int model_target(input logic [63:0] a);
      for (int r = 0; r < NS; r++) begin
         if ((a >= M_BASE[r]) && ((a - M_BASE[r]) < M_LEN[r])) return r;
      end
      return -1;
   endfunction

   function automatic logic [63:0] rand_addr(input int r);
      logic [63:0] off;
      if (r >= NS) return {$urandom, $urandom};
      case ($urandom_range(0, 3))
         0:       off = 64'd0;
         1:       off = M_LEN[r] - 64'd1;
         2:       off = M_LEN[r];
         default: off = 64'($urandom) % M_LEN[r];
      endcase
      return M_BASE[r] + off;
   endfunction

   task automatic clear_inputs();
      bus.req_valid_i     = 1'b0;
      bus.req_addr_i      = '0;
      bus.req_id_i        = '0;
      bus.req_we_i        = 1'b0;
      bus.slv_ready_i     = '0;
      bus.rsp_valid_i     = '0;
      bus.err_rsp_ready_i = 1'b0;
   endtask

   // Starts and ends at posedge+1; returns once the request has been taken.
   task automatic issue(input logic [63:0] a, input logic [3:0] id, input logic we);
      int n;
      n = 0;
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = a;
      bus.req_id_i    = id;
      bus.req_we_i    = we;
      smp();
      while (!bus.req_ready_o && n < 50) begin
         step();
         smp();
         n++;
      end
      chk("issue_accept", bus.req_ready_o, 1);
      step();
      bus.req_valid_i = 1'b0;
   endtask

   task automatic fwd_complete(input logic [9:0] oh, input logic [63:0] a, input logic [3:0] id,
                               input logic we);
      smp();
      chk("slv_vld", bus.slv_valid_o, oh);
      chk("slv_addr", bus.slv_addr_o, a);
      chk("slv_id", bus.slv_id_o, id);
      chk("slv_we", bus.slv_we_o, we);
      chk("fwd_req_rdy_low", bus.req_ready_o, 0);
      step();
      bus.slv_ready_i = '1;
      smp();
      chk("slv_vld_hold", bus.slv_valid_o, oh);
      chk("slv_addr_hold", bus.slv_addr_o, a);
      step();
      bus.slv_ready_i = '0;
   endtask

   task automatic rsp_complete(input logic [9:0] oh);
      smp();
      chk("fwd_cnt", outstanding_o, 1);
      chk("rsp_rdy", bus.rsp_ready_o, oh);
      chk("slv_vld_clr", bus.slv_valid_o, 0);
      step();
      bus.rsp_valid_i = ~oh;
      smp();
      step();
      bus.rsp_valid_i = oh;
      smp();
      chk("rsp_other_ignored", outstanding_o, 1);
      step();
      bus.rsp_valid_i = '0;
      smp();
      chk("rsp_cnt", outstanding_o, 0);
      chk("rsp_rdy_clr", bus.rsp_ready_o, 0);
      step();
   endtask

   task automatic err_complete(input logic [3:0] id);
      smp();
      chk("err_vld", bus.err_rsp_valid_o, 1);
      chk("err_id", bus.err_rsp_id_o, id);
      chk("err_no_slv_vld", bus.slv_valid_o, 0);
      step();
      smp();
      chk("err_vld_hold", bus.err_rsp_valid_o, 1);
      chk("err_id_hold", bus.err_rsp_id_o, id);
      step();
      bus.err_rsp_ready_i = 1'b1;
      smp();
      step();
      bus.err_rsp_ready_i = 1'b0;
      exp_errs++;
      smp();
      chk("err_vld_clr", bus.err_rsp_valid_o, 0);
      chk("err_count", err_count_o, exp_ec());
      chk("err_no_outstanding", outstanding_o, 0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [17];
      txn_t fwd_q[$];
      txn_t err_q[$];
      int   m_cnt;
      int   m_cur;
      int   last_r;

      vecs = '{
         '{64'h0000_0000_1000_0004, 4'd3,  10'h020, 1'b0},
         '{64'h0000_0000_0000_2000, 4'd7,  10'h000, 1'b1},
         '{64'h0000_0000_BFFF_FFFF, 4'd1,  10'h001, 1'b0},
         '{64'h0000_0000_C000_0000, 4'd2,  10'h000, 1'b1},
         '{64'h0000_0000_0001_0000, 4'd4,  10'h100, 1'b0},
         '{64'h0000_0000_0000_0FFF, 4'd5,  10'h200, 1'b0},
         '{64'h0000_0000_4000_0FFF, 4'd6,  10'h002, 1'b0},
         '{64'h0000_0000_4000_1000, 4'd8,  10'h000, 1'b1},
         '{64'h0000_0000_3000_FFFF, 4'd9,  10'h004, 1'b0},
         '{64'h0000_0000_207F_FFFF, 4'd10, 10'h008, 1'b0},
         '{64'h0000_0000_1800_0000, 4'd11, 10'h010, 1'b0},
         '{64'h0000_0000_0FFF_FFFE, 4'd12, 10'h040, 1'b0},
         '{64'h0000_0000_0FFF_FFFF, 4'd13, 10'h000, 1'b1},
         '{64'h0000_0000_020B_FFFF, 4'd14, 10'h080, 1'b0},
         '{64'h0000_0000_0001_FFFF, 4'd15, 10'h100, 1'b0},
         '{64'h0000_0001_8000_0000, 4'd0,  10'h000, 1'b1},
         '{64'h0000_0000_0000_1000, 4'd1,  10'h000, 1'b1}
      };

      clear_inputs();
      #12;
      chk("rst_slv_vld", bus.slv_valid_o, 0);
      chk("rst_err_vld", bus.err_rsp_valid_o, 0);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_err_count", err_count_o, 0);
      chk("rst_rsp_rdy", bus.rsp_ready_o, 0);
      chk("rst_slv_addr", bus.slv_addr_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();

      for (int i = 0; i < 17; i++) begin
         issue(vecs[i].addr, vecs[i].id, vecs[i].id[0]);
         if (vecs[i].exp_err) begin
            err_complete(vecs[i].id);
         end else begin
            fwd_complete(vecs[i].exp_vld, vecs[i].addr, vecs[i].id, vecs[i].id[0]);
            rsp_complete(vecs[i].exp_vld);
         end
      end

      // DRAM still owed a response, so the UART request must wait for it.
      issue(64'h8000_1000, 4'd1, 1'b0);
      fwd_complete(10'h001, 64'h8000_1000, 4'd1, 1'b0);
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 64'h1000_0010;
      bus.req_id_i    = 4'd2;
      bus.req_we_i    = 1'b1;
      smp();
      chk("order_stall_0", bus.req_ready_o, 0);
      step();
      smp();
      chk("order_stall_1", bus.req_ready_o, 0);
      step();
      bus.rsp_valid_i = 10'h001;
      smp();
      chk("order_stall_pre_dec", bus.req_ready_o, 0);
      step();
      bus.rsp_valid_i = '0;
      smp();
      chk("order_cnt_zero", outstanding_o, 0);
      chk("order_ready", bus.req_ready_o, 1);
      step();
      bus.req_valid_i = 1'b0;
      fwd_complete(10'h020, 64'h1000_0010, 4'd2, 1'b1);
      rsp_complete(10'h020);

      // Fill to MAX_OUTSTANDING, then exercise the full-count stall.
      for (int k = 0; k < MAXO; k++) begin
         issue(64'h8000_0000 + 64'(k * 16), 4'(k), 1'b1);
         bus.slv_ready_i = '1;
         step();
         bus.slv_ready_i = '0;
      end
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 64'h8000_0100;
      bus.req_id_i    = 4'd9;
      smp();
      chk("full_cnt", outstanding_o, MAXO);
      chk("full_stall_0", bus.req_ready_o, 0);
      step();
      bus.rsp_valid_i = 10'h001;
      smp();
      chk("full_stall_pre_dec", bus.req_ready_o, 0);
      step();
      bus.rsp_valid_i = '0;
      smp();
      chk("full_after_rsp_cnt", outstanding_o, MAXO - 1);
      chk("full_after_rsp_rdy", bus.req_ready_o, 1);
      step();
      bus.req_valid_i = 1'b0;
      bus.slv_ready_i = 10'h001;
      bus.rsp_valid_i = 10'h001;
      smp();
      chk("both_hs_slv_vld", bus.slv_valid_o, 10'h001);
      step();
      bus.slv_ready_i = '0;
      bus.rsp_valid_i = '0;
      smp();
      chk("both_hs_cnt_same", outstanding_o, MAXO - 1);
      step();
      issue(64'h8000_0200, 4'd10, 1'b0);
      bus.slv_ready_i = 10'h001;
      step();
      bus.slv_ready_i = '0;
      smp();
      chk("refill_cnt", outstanding_o, MAXO);
      step();
      bus.rsp_valid_i = 10'h001;
      repeat (MAXO + 2) step();
      bus.rsp_valid_i = '0;
      smp();
      chk("drain_no_underflow", outstanding_o, 0);
      step();

      // Reset while a forward is pending and one response is owed.
      issue(64'h8000_0040, 4'd3, 1'b0);
      bus.slv_ready_i = '1;
      step();
      bus.slv_ready_i = '0;
      issue(64'h8000_0080, 4'd4, 1'b0);
      #2;
      chk("prerst_slv_vld", bus.slv_valid_o, 10'h001);
      chk("prerst_cnt", outstanding_o, 1);
      rst_ni = 1'b0;
      #1;
      chk("midrst_slv_vld", bus.slv_valid_o, 0);
      chk("midrst_cnt", outstanding_o, 0);
      chk("midrst_rsp_rdy", bus.rsp_ready_o, 0);
      exp_errs = 0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();
      smp();
      chk("postrst_slv_vld", bus.slv_valid_o, 0);
      chk("postrst_err_count", err_count_o, exp_ec());
      step();
      issue(64'h4000_0010, 4'd6, 1'b1);
      fwd_complete(10'h002, 64'h4000_0010, 4'd6, 1'b1);
      rsp_complete(10'h002);

      // Random traffic against the transaction-level model.
      rst_ni = 1'b0;
      clear_inputs();
      #3;
      @(negedge clk_i);
      rst_ni = 1'b1;
      exp_errs = 0;
      m_cnt = 0;
      m_cur = 0;
      last_r = 0;
      step();
      for (int c = 0; c < 2500; c++) begin
         int          t;
         logic        exp_rdy;
         logic [9:0]  exp_vld;
         logic [9:0]  exp_rrdy;
         logic        fwd_hs;
         logic        rsp_hs;
         logic        err_hs;

         if ($urandom_range(0, 1) == 0) last_r = $urandom_range(0, NS);
         bus.req_valid_i     = ($urandom_range(0, 9) < 7);
         bus.req_addr_i      = rand_addr(last_r);
         bus.req_id_i        = 4'($urandom);
         bus.req_we_i        = 1'($urandom);
         bus.slv_ready_i     = 10'($urandom);
         bus.rsp_valid_i     = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'h000;
         bus.err_rsp_ready_i = 1'($urandom);
         smp();

         t        = model_target(bus.req_addr_i);
         exp_rdy  = (fwd_q.size() == 0) && (err_q.size() == 0) && (m_cnt < MAXO) &&
                    !((m_cnt > 0) && ((t < 0) || (t != m_cur)));
         exp_vld  = (fwd_q.size() != 0) ? (10'h001 << fwd_q[0].tgt) : 10'h000;
         exp_rrdy = (m_cnt > 0) ? (10'h001 << m_cur) : 10'h000;
         chk("rnd_req_rdy", bus.req_ready_o, exp_rdy);
         chk("rnd_slv_vld", bus.slv_valid_o, exp_vld);
         chk("rnd_rsp_rdy", bus.rsp_ready_o, exp_rrdy);
         chk("rnd_err_vld", bus.err_rsp_valid_o, (err_q.size() != 0));
         chk("rnd_outstanding", outstanding_o, m_cnt);
         chk("rnd_err_count", err_count_o, exp_ec());
         if (fwd_q.size() != 0) begin
            chk("rnd_slv_addr", bus.slv_addr_o, fwd_q[0].a);
            chk("rnd_slv_id", bus.slv_id_o, fwd_q[0].id);
            chk("rnd_slv_we", bus.slv_we_o, fwd_q[0].we);
         end
         if (err_q.size() != 0) chk("rnd_err_id", bus.err_rsp_id_o, err_q[0].id);

         fwd_hs = (fwd_q.size() != 0) && bus.slv_ready_i[fwd_q[0].tgt];
         rsp_hs = (m_cnt > 0) && bus.rsp_valid_i[m_cur];
         err_hs = (err_q.size() != 0) && bus.err_rsp_ready_i;
         m_cnt  = m_cnt + int'(fwd_hs) - int'(rsp_hs);
         if (fwd_hs) void'(fwd_q.pop_front());
         if (err_hs) begin
            void'(err_q.pop_front());
            exp_errs++;
         end
         if (bus.req_valid_i && exp_rdy) begin
            if (t >= 0) begin
               fwd_q.push_back('{bus.req_addr_i, bus.req_id_i, bus.req_we_i, t});
               m_cur = t;
            end else begin
               err_q.push_back('{bus.req_addr_i, bus.req_id_i, bus.req_we_i, t});
            end
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
